spi_inst_fifo_rx: RTL and testbench
===================================

# spi_inst_fifo_rx

Parametrised SPI instruction receiver for the Raspberry Pi accelerator interface. It deserialises MOSI frames of `INST_WIDTH` bits framed by active-low `cs1` and checks frame length. Complete instructions are queued in a `FIFO_DEPTH`-entry first-word-fall-through buffer with a valid/ready handshake to the accelerator core. During each frame it returns an 8-bit status byte on MISO.

## Interface

**Parameters**
- `INST_WIDTH`, 80: bits per instruction frame. Must be at least 8.
- `FIFO_DEPTH`, 4: number of instruction queue entries. Legal values are 2, 4 and 8.

**Ports**
- `RPiclk` in 1: the single clock. All logic is on its rising edge, and MOSI and `cs1` are sampled there.
- `rst` in 1: asynchronous, active-high reset.
- `cs1` in 1: chip select, active-low. It frames one transfer.
- `MOSI` in 1: serial data, MSB first.
- `MISO` out 1: serial status, MSB first.
- `inst_data` out `INST_WIDTH`: head of the queue. The first-received bit is in the MSB.
- `inst_valid` out 1: asserted when the queue is non-empty.
- `inst_ready` in 1: the consumer accepts the head entry when `inst_valid & inst_ready`.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `err_short` out 1: sticky. A frame ended before `INST_WIDTH` bits.
- `err_long` out 1: sticky. More than `INST_WIDTH` bits were clocked in one frame.
- `overflow` out 1: sticky. A complete frame was dropped because the queue was full.
- `clear_err` in 1: synchronous clear of all three sticky flags.

## Operation

**States: IDLE, SHIFT, HOLD.**
- **IDLE**
  - With `cs1`=1: stay in IDLE, `bit_cnt`=0, and load `status_sr` with the status snapshot every cycle.
  - With `cs1`=0: shift MOSI into `shift_sr`, set `bit_cnt`=1, shift `status_sr` left by one, go to SHIFT.
- **SHIFT**
  - With `cs1`=0: shift MOSI in and increment `bit_cnt`. On the edge that samples bit number `INST_WIDTH`, push `{shift_sr[INST_WIDTH-2:0], MOSI}` and go to HOLD.
  - With `cs1`=1: discard the partial frame, set `err_short`, go to IDLE. No push occurs.
- **HOLD**
  - With `cs1`=0: ignore MOSI. Set `err_long` on the first such edge (and hold it thereafter). Stay in HOLD.
  - With `cs1`=1: go to IDLE.

**Status byte**
- Bit layout: `{overflow, err_short, err_long, full, count[3:0]}`. `count` is `fifo_count` zero-extended; `full` is `fifo_count==FIFO_DEPTH`.
- `MISO` = `status_sr[7]`. `status_sr` shifts left (filling with 0) on each sampled bit in SHIFT/HOLD.
- Result: the master receives status bit 7 before its first edge, then bits 6..0, then zeros.

**Queue**
- Storage is a circular buffer with read/write pointers wrapping modulo `FIFO_DEPTH`.
- A push is accepted if `fifo_count<FIFO_DEPTH`, or if a pop occurs in the same cycle.
- Otherwise the frame is dropped, `overflow` is set, and contents are unchanged.
- A pop occurs on `inst_valid & inst_ready`. `inst_ready` while empty has no effect.
- `fifo_count` updates as +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.

**Sticky flags**
- `clear_err` clears all three flags.
- If a set event and `clear_err` occur in the same cycle, the flag is set (set wins).

## Timing

**Reset values**
- State IDLE; `bit_cnt` 0; `shift_sr` 0; `status_sr` 0.
- `MISO` 0; `inst_data` 0 (storage is reset); `inst_valid` 0; `fifo_count` 0.
- `err_short`, `err_long`, `overflow` all 0.
- Reset asserted mid-frame aborts the frame with no push and no error flag. After release, the block waits in IDLE.

**Latency**
- The last bit is sampled at edge E.
- If the queue is empty, `inst_valid`=1 and `inst_data` are valid after E.
- The consumer may pop at edge E+1.

**Back-to-back frames**
- `cs1` must be high for at least one edge between frames.
- A frame begins on the first edge where `cs1`=0 while in IDLE.

**Other rules**
- Error flags and `overflow` change on the same edge as the causing event.
- The status snapshot reflects state as of the last IDLE edge before the frame.

## Test plan

- **Single frame, reset state.** After reset, one 80-bit frame `0xA5` followed by 72 bits of `0x00…01`, then `cs1` high. Required: `inst_valid`=1 after bit 80; `inst_data` = the frame; `fifo_count`=1; MISO during the first 8 bits = `0x00`.
- **Fill and overflow.** 5 frames with `inst_ready`=0 at `FIFO_DEPTH`=4. Required: `fifo_count`=4; `overflow`=1 after frame 5; the head is frame 1. The next frame's MISO byte is `0x94`.
- **Short frame.** 40 bits, then `cs1` high. Required: `err_short`=1, `fifo_count` unchanged, no `inst_valid` rise. Asserting `clear_err` for one cycle returns `err_short` to 0.
- **Long frame.** 85 bits in one frame. Required: exactly one push with the first 80 bits; `err_long`=1 from edge 81.
- **Push/pop while full.** Queue full and `inst_ready`=1 on the push edge of a 5th frame. Required: no overflow, `fifo_count` stays 4, the pop returns frame 1, and the pointers wrap correctly.
- **Reset mid-frame.** Assert `rst` at bit 30, then a complete frame. Required: only the second frame is queued and all flags are 0.

Source files
------------

// File: rtl/spi_inst_fifo_rx.sv
// SPI instruction receiver: deserialises cs1-framed MOSI instructions into a
// first-word-fall-through queue and returns a status byte on MISO.
module spi_inst_fifo_rx #(
  parameter int INST_WIDTH = 80,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          RPiclk,
  input  logic                          rst,
  input  logic                          cs1,
  input  logic                          MOSI,
  output logic                          MISO,
  output logic [INST_WIDTH-1:0]         inst_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_short,
  output logic                          err_long,
  output logic                          overflow,
  input  logic                          clear_err
);

  localparam int CW = $clog2(INST_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(INST_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [INST_WIDTH-2:0]  shift_sr;
  logic [7:0]             status_sr;
  logic [7:0]             status_snap;

  logic [INST_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  logic                   full;
  logic                   push_req;
  logic                   push_ok;
  logic                   pop;
  logic [INST_WIDTH-1:0]  push_data;

  assign full        = (fifo_count == DEPTH_CNT);
  assign status_snap = {overflow, err_short, err_long, full, 4'(fifo_count)};
  assign MISO        = status_sr[7];
  assign inst_valid  = (fifo_count != '0);
  assign inst_data   = mem[rd_ptr];
  assign pop         = inst_valid & inst_ready;

  always_comb begin
    push_req  = 1'b0;
    push_data = {shift_sr, MOSI};
    if (state == SHIFT && !cs1 && bit_cnt == LAST_BIT)
      push_req = 1'b1;
  end

  assign push_ok = push_req && ((fifo_count < DEPTH_CNT) || pop);

  // The snapshot is reloaded on every deselected edge so a single high edge
  // between frames is enough to present fresh status to the next frame.
  always_ff @(posedge RPiclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      status_sr <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (cs1)
        status_sr <= status_snap;
      else
        status_sr <= {status_sr[6:0], 1'b0};

      case (state)
        IDLE: begin
          if (cs1) begin
            bit_cnt <= '0;
          end else begin
            shift_sr <= {shift_sr[INST_WIDTH-3:0], MOSI};
            bit_cnt  <= CW'(1);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs1) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            shift_sr <= {shift_sr[INST_WIDTH-3:0], MOSI};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (cs1) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == SHIFT && cs1)
        err_short <= 1'b1;
      else if (clear_err)
        err_short <= 1'b0;

      if (state == HOLD && !cs1)
        err_long <= 1'b1;
      else if (clear_err)
        err_long <= 1'b0;
    end
  end

  // A push into a full queue still succeeds when the head leaves on the same edge.
  always_ff @(posedge RPiclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (push_ok && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !push_ok)
        fifo_count <= fifo_count - 1'b1;

      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (clear_err)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_inst_fifo_rx.sv
// Directed bench for spi_inst_fifo_rx with hand-computed expected values.
module tb_spi_inst_fifo_rx;

  logic        RPiclk = 1'b0;
  logic        rst = 1'b1;
  logic        cs1 = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [79:0] inst_data;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        err_short;
  logic        err_long;
  logic        overflow;
  logic        clear_err = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_inst_fifo_rx #(.INST_WIDTH(80), .FIFO_DEPTH(4)) dut (
    .RPiclk     (RPiclk),
    .rst        (rst),
    .cs1        (cs1),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fifo_count (fifo_count),
    .err_short  (err_short),
    .err_long   (err_long),
    .overflow   (overflow),
    .clear_err  (clear_err)
  );

  always #5 RPiclk = ~RPiclk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends nbits of a frame (bits past 80 are ones), captures the first MISO byte,
  // and optionally raises inst_ready only on the final bit's edge.
  task automatic applyStimulus(input logic [79:0] frame, input int nbits,
                               input bit ready_on_last, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge RPiclk);
      cs1  = 1'b0;
      MOSI = (i < 80) ? frame[79 - i] : 1'b1;
      inst_ready = (ready_on_last && i == nbits - 1);
      if (i < 8) miso_byte[7 - i] = MISO;
    end
    @(negedge RPiclk);
    cs1 = 1'b1;
    MOSI = 1'b0;
    inst_ready = 1'b0;
    @(negedge RPiclk);
    @(negedge RPiclk);
  endtask

  task automatic pulseReady();
    @(negedge RPiclk);
    inst_ready = 1'b1;
    @(negedge RPiclk);
    inst_ready = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge RPiclk);
    clear_err = 1'b1;
    @(negedge RPiclk);
    clear_err = 1'b0;
  endtask

  logic [79:0] f1;
  logic [79:0] fill [5];
  logic [79:0] g, lng, rf, sf;
  logic [7:0]  mb;

  initial begin
    f1      = {8'hA5, 72'h1};
    fill[0] = 80'h0123_4567_89AB_CDEF_0011;
    fill[1] = 80'hFEDC_BA98_7654_3210_FFEE;
    fill[2] = 80'h8000_0000_0000_0000_0001;
    fill[3] = 80'h5555_AAAA_5555_AAAA_5555;
    fill[4] = 80'hDEAD_BEEF_CAFE_F00D_1234;
    g       = 80'h1357_9BDF_2468_ACE0_7777;
    sf      = 80'hFFFF_0000_FFFF_0000_FFFF;
    lng     = 80'hC3C3_3C3C_C3C3_3C3C_C3C3;
    rf      = 80'h0F0F_F0F0_1234_5678_9ABC;

    repeat (3) @(negedge RPiclk);
    checkOutput("reset_miso", MISO, 1'b0);
    checkOutput("reset_valid", inst_valid, 1'b0);
    checkOutput("reset_count", fifo_count, 3'd0);
    checkOutput("reset_data", inst_data, 80'h0);
    checkOutput("reset_flags", {overflow, err_short, err_long}, 3'b000);
    rst = 1'b0;
    repeat (2) @(negedge RPiclk);

    // Single frame after reset
    applyStimulus(f1, 80, 1'b0, mb);
    checkOutput("single_miso", mb, 8'h00);
    checkOutput("single_valid", inst_valid, 1'b1);
    checkOutput("single_data", inst_data, f1);
    checkOutput("single_count", fifo_count, 3'd1);
    checkOutput("single_flags", {overflow, err_short, err_long}, 3'b000);
    pulseReady();
    checkOutput("pop_count", fifo_count, 3'd0);
    checkOutput("pop_valid", inst_valid, 1'b0);
    pulseReady();
    checkOutput("empty_ready_count", fifo_count, 3'd0);

    // Fill and overflow
    for (int k = 0; k < 5; k++) begin
      applyStimulus(fill[k], 80, 1'b0, mb);
      checkOutput($sformatf("fill_miso_%0d", k), mb, (k == 4) ? 8'h14 : 8'(k));
    end
    checkOutput("fill_count", fifo_count, 3'd4);
    checkOutput("fill_overflow", overflow, 1'b1);
    checkOutput("fill_head", inst_data, fill[0]);
    applyStimulus(fill[4], 80, 1'b0, mb);
    checkOutput("ovf_status_miso", mb, 8'h94);
    checkOutput("ovf_head_kept", inst_data, fill[0]);
    pulseClear();
    checkOutput("ovf_cleared", overflow, 1'b0);

    // Push and pop on the same edge while full
    checkOutput("full_head_before", inst_data, fill[0]);
    applyStimulus(g, 80, 1'b1, mb);
    checkOutput("pp_miso", mb, 8'h14);
    checkOutput("pp_overflow", overflow, 1'b0);
    checkOutput("pp_count", fifo_count, 3'd4);
    checkOutput("pp_head", inst_data, fill[1]);
    checkOutput("drain_0", inst_data, fill[1]);
    pulseReady();
    checkOutput("drain_1", inst_data, fill[2]);
    pulseReady();
    checkOutput("drain_2", inst_data, fill[3]);
    pulseReady();
    checkOutput("drain_3", inst_data, g);
    pulseReady();
    checkOutput("drain_count", fifo_count, 3'd0);

    // Short frame
    applyStimulus(sf, 40, 1'b0, mb);
    checkOutput("short_err", err_short, 1'b1);
    checkOutput("short_count", fifo_count, 3'd0);
    checkOutput("short_valid", inst_valid, 1'b0);
    checkOutput("short_long", err_long, 1'b0);
    pulseClear();
    checkOutput("short_cleared", err_short, 1'b0);

    // Long frames: 85 bits, then the 81-bit boundary
    applyStimulus(lng, 85, 1'b0, mb);
    checkOutput("long_err", err_long, 1'b1);
    checkOutput("long_count", fifo_count, 3'd1);
    checkOutput("long_data", inst_data, lng);
    checkOutput("long_short", err_short, 1'b0);
    pulseReady();
    pulseClear();
    checkOutput("long_cleared", err_long, 1'b0);
    applyStimulus(g, 81, 1'b0, mb);
    checkOutput("long81_err", err_long, 1'b1);
    checkOutput("long81_data", inst_data, g);
    pulseReady();
    pulseClear();

    // Reset mid-frame
    for (int i = 0; i < 30; i++) begin
      @(negedge RPiclk);
      cs1  = 1'b0;
      MOSI = sf[79 - i];
    end
    @(negedge RPiclk);
    rst = 1'b1;
    cs1 = 1'b1;
    repeat (2) @(negedge RPiclk);
    rst = 1'b0;
    repeat (2) @(negedge RPiclk);
    checkOutput("midrst_count", fifo_count, 3'd0);
    checkOutput("midrst_flags", {overflow, err_short, err_long}, 3'b000);
    applyStimulus(rf, 80, 1'b0, mb);
    checkOutput("midrst_frame_count", fifo_count, 3'd1);
    checkOutput("midrst_frame_data", inst_data, rf);
    checkOutput("midrst_frame_flags", {overflow, err_short, err_long}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
